// File: rtl/display_scan_ctrl.sv
// Scans a shared 3-input segment decoder across NUM_DIGITS common-anode digits,
// with a blanking gap before each slot and frame-aligned double-buffered codes.
module display_scan_ctrl #(
    parameter int unsigned NUM_DIGITS   = 4,
    parameter int unsigned PRESCALE     = 50000,
    parameter int unsigned BLANK_CYCLES = 16
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      en,
    input  logic                      upd_strobe,
    input  logic [3*NUM_DIGITS-1:0]   upd_codes,
    input  logic [NUM_DIGITS-1:0]     digit_mask,
    output logic                      dec_a,
    output logic                      dec_b,
    output logic                      dec_c,
    output logic [NUM_DIGITS-1:0]     digit_sel,
    output logic                      upd_busy,
    output logic                      frame_tick
);

    localparam int unsigned CODE_W  = 3 * NUM_DIGITS;
    localparam int unsigned IDX_W   = $clog2(NUM_DIGITS);
    localparam int unsigned CNT_MAX = (PRESCALE > BLANK_CYCLES) ? PRESCALE : BLANK_CYCLES;
    localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);

    localparam logic [CNT_W-1:0] BLANK_LAST = CNT_W'(BLANK_CYCLES - 1);
    localparam logic [CNT_W-1:0] SHOW_LAST  = CNT_W'(PRESCALE - 1);
    localparam logic [IDX_W-1:0] IDX_LAST   = IDX_W'(NUM_DIGITS - 1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_BLANK = 2'd1,
        ST_SHOW  = 2'd2
    } state_e;

    state_e                  state_q, state_d;
    logic [IDX_W-1:0]        idx_q, idx_d;
    logic [CNT_W-1:0]        cnt_q, cnt_d;
    logic [CODE_W-1:0]       shadow_q, shadow_d;
    logic [CODE_W-1:0]       staging_q, staging_d;
    logic                    busy_q, busy_d;
    logic                    tick_q, tick_d;
    logic [2:0]              dec_q, dec_d;
    logic [NUM_DIGITS-1:0]   sel_q, sel_d;
    logic [2:0]              cur_code;

    // State and output registers
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            idx_q     <= '0;
            cnt_q     <= '0;
            shadow_q  <= '0;
            staging_q <= '0;
            busy_q    <= 1'b0;
            tick_q    <= 1'b0;
            dec_q     <= '0;
            sel_q     <= '1;
        end else begin
            state_q   <= state_d;
            idx_q     <= idx_d;
            cnt_q     <= cnt_d;
            shadow_q  <= shadow_d;
            staging_q <= staging_d;
            busy_q    <= busy_d;
            tick_q    <= tick_d;
            dec_q     <= dec_d;
            sel_q     <= sel_d;
        end
    end

    // Next-state, update handshake and registered-output logic
    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        cnt_d     = cnt_q;
        shadow_d  = shadow_q;
        staging_d = staging_q;
        busy_d    = busy_q;
        tick_d    = 1'b0;
        dec_d     = dec_q;
        sel_d     = '1;
        cur_code  = '0;

        // The frame boundary is the cycle frame_tick is high; a strobe there
        // (or while idle) bypasses staging so it is never shadowed by older data.
        if (state_q == ST_IDLE || tick_q) begin
            if (upd_strobe) begin
                shadow_d = upd_codes;
                busy_d   = 1'b0;
            end else if (tick_q && busy_q) begin
                shadow_d = staging_q;
                busy_d   = 1'b0;
            end
        end else if (upd_strobe) begin
            staging_d = upd_codes;
            busy_d    = 1'b1;
        end

        for (int unsigned i = 0; i < NUM_DIGITS; i++) begin
            if (idx_q == IDX_W'(i)) begin
                cur_code = shadow_d[3*i +: 3];
            end
        end

        case (state_q)
            ST_IDLE: begin
                if (en) begin
                    idx_d   = '0;
                    cnt_d   = '0;
                    state_d = ST_BLANK;
                end
            end
            ST_BLANK: begin
                dec_d = cur_code;
                if (cnt_q == BLANK_LAST) begin
                    cnt_d   = '0;
                    state_d = ST_SHOW;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            ST_SHOW: begin
                for (int unsigned i = 0; i < NUM_DIGITS; i++) begin
                    if (idx_q == IDX_W'(i) && digit_mask[i]) begin
                        sel_d[i] = 1'b0;
                    end
                end
                if (cnt_q == SHOW_LAST) begin
                    cnt_d = '0;
                    if (idx_q == IDX_LAST) begin
                        idx_d  = '0;
                        tick_d = 1'b1;
                    end else begin
                        idx_d = idx_q + IDX_W'(1);
                    end
                    state_d = en ? ST_BLANK : ST_IDLE;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    assign dec_a      = dec_q[2];
    assign dec_b      = dec_q[1];
    assign dec_c      = dec_q[0];
    assign digit_sel  = sel_q;
    assign upd_busy   = busy_q;
    assign frame_tick = tick_q;

endmodule

// File: tb/tb_display_scan_ctrl.sv
// Self-checking bench for display_scan_ctrl: directed vector table, corner-case
// sequences and randomized traffic against a frame-position reference model.
module tb_display_scan_ctrl;

    localparam int unsigned ND    = 4;
    localparam int unsigned PRE   = 4;
    localparam int unsigned BLK   = 2;
    localparam int unsigned SLOT  = PRE + BLK;
    localparam int unsigned FRAME = ND * SLOT;

    logic            clk;
    logic            rst_n;
    logic            en;
    logic            upd_strobe;
    logic [3*ND-1:0] upd_codes;
    logic [ND-1:0]   digit_mask;
    logic            dec_a, dec_b, dec_c;
    logic [ND-1:0]   digit_sel;
    logic            upd_busy;
    logic            frame_tick;

    display_scan_ctrl #(
        .NUM_DIGITS  (ND),
        .PRESCALE    (PRE),
        .BLANK_CYCLES(BLK)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .en        (en),
        .upd_strobe(upd_strobe),
        .upd_codes (upd_codes),
        .digit_mask(digit_mask),
        .dec_a     (dec_a),
        .dec_b     (dec_b),
        .dec_c     (dec_c),
        .digit_sel (digit_sel),
        .upd_busy  (upd_busy),
        .frame_tick(frame_tick)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;

    // Reference model: position within the frame schedule plus code buffers
    bit              m_run;
    int              m_pos;
    logic [3*ND-1:0] m_shadow;
    logic [3*ND-1:0] m_pend;
    bit              m_pend_v;
    logic [ND-1:0]   exp_sel;
    logic [2:0]      exp_dec;
    logic            exp_tick;
    logic            exp_busy;

    function automatic void model_step();
        int k, o;
        logic [ND-1:0] n_sel;
        logic n_tick;
        bit boundary;
        if (!rst_n) begin
            m_run = 0; m_pos = 0; m_shadow = '0; m_pend = '0; m_pend_v = 0;
            exp_sel = '1; exp_dec = '0; exp_tick = 1'b0; exp_busy = 1'b0;
            return;
        end
        boundary = (exp_tick === 1'b1);
        if (!m_run || boundary) begin
            if (upd_strobe) begin
                m_shadow = upd_codes; m_pend_v = 0;
            end else if (boundary && m_pend_v) begin
                m_shadow = m_pend; m_pend_v = 0;
            end
        end else if (upd_strobe) begin
            m_pend = upd_codes; m_pend_v = 1;
        end
        n_sel  = '1;
        n_tick = 1'b0;
        if (m_run) begin
            k = m_pos / SLOT;
            o = m_pos % SLOT;
            if (o < BLK) exp_dec = m_shadow[3*k +: 3];
            else if (digit_mask[k]) n_sel[k] = 1'b0;
            n_tick = (m_pos == FRAME - 1);
            if (o == SLOT - 1 && !en) m_run = 0;
            else m_pos = (m_pos + 1) % FRAME;
        end else if (en) begin
            m_run = 1;
            m_pos = 0;
        end
        exp_sel  = n_sel;
        exp_tick = n_tick;
        exp_busy = m_pend_v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
        n_tests++;
        if (act !== expv) begin
            n_fail++;
            $display("FAIL %s cyc=%0d: got %h expected %h", name, cyc, act, expv);
        end
    endtask

    function automatic logic [31:0] outs();
        return 32'({digit_sel, dec_a, dec_b, dec_c, frame_tick, upd_busy});
    endfunction

    task automatic step();
        model_step();
        @(posedge clk);
        #1;
        cyc++;
        check("model", outs(), 32'({exp_sel, exp_dec, exp_tick, exp_busy}));
    endtask

    task automatic wait_sel(input logic [ND-1:0] target, input string name);
        bit hit = 0;
        for (int i = 0; i < 100 && !hit; i++) begin
            step();
            if (digit_sel === target) hit = 1;
        end
        if (!hit) check({name, "_timeout"}, 32'(digit_sel), 32'(target));
    endtask

    task automatic wait_tick(input string name);
        bit hit = 0;
        for (int i = 0; i < 100 && !hit; i++) begin
            step();
            if (frame_tick === 1'b1) hit = 1;
        end
        if (!hit) check({name, "_timeout"}, 32'(frame_tick), 32'd1);
    endtask

    typedef struct {
        logic            rst_n;
        logic            en;
        logic            stb;
        logic [3*ND-1:0] codes;
        logic [ND-1:0]   mask;
        logic [ND-1:0]   sel;
        logic [2:0]      dec;
        logic            tick;
        logic            busy;
    } vec_t;

    vec_t vecs[14];

    function automatic vec_t mk(logic r, logic e, logic s, logic [3*ND-1:0] c,
                                logic [ND-1:0] sl, logic [2:0] d);
        vec_t v;
        v.rst_n = r; v.en = e; v.stb = s; v.codes = c; v.mask = '1;
        v.sel = sl; v.dec = d; v.tick = 1'b0; v.busy = 1'b0;
        return v;
    endfunction

    initial begin
        logic [3*ND-1:0] codes_c;
        logic [3*ND-1:0] codes_d;
        int t_first, t_second, busy_seen, lit2;

        clk = 1'b0; rst_n = 1'b0; en = 1'b1; upd_strobe = 1'b0;
        upd_codes = '0; digit_mask = '1;
        exp_tick = 1'b0;
        codes_c = {3'd7, 3'd5, 3'd2, 3'd1};
        codes_d = {3'd4, 3'd6, 3'd5, 3'd3};

        // Reset, idle load and first two slots of the scan
        for (int i = 0; i < 3; i++) vecs[i] = mk(1'b0, 1'b1, 1'b0, '0, 4'b1111, 3'd0);
        vecs[3] = mk(1'b1, 1'b0, 1'b1, codes_c, 4'b1111, 3'd0);
        vecs[4] = mk(1'b1, 1'b1, 1'b0, codes_c, 4'b1111, 3'd0);
        vecs[5] = mk(1'b1, 1'b1, 1'b0, codes_c, 4'b1111, 3'd1);
        vecs[6] = mk(1'b1, 1'b1, 1'b0, codes_c, 4'b1111, 3'd1);
        for (int i = 7; i < 11; i++) vecs[i] = mk(1'b1, 1'b1, 1'b0, codes_c, 4'b1110, 3'd1);
        vecs[11] = mk(1'b1, 1'b1, 1'b0, codes_c, 4'b1111, 3'd2);
        vecs[12] = mk(1'b1, 1'b1, 1'b0, codes_c, 4'b1111, 3'd2);
        vecs[13] = mk(1'b1, 1'b1, 1'b0, codes_c, 4'b1101, 3'd2);

        for (int i = 0; i < 14; i++) begin
            rst_n = vecs[i].rst_n; en = vecs[i].en; upd_strobe = vecs[i].stb;
            upd_codes = vecs[i].codes; digit_mask = vecs[i].mask;
            step();
            check($sformatf("vec%0d", i), outs(),
                  32'({vecs[i].sel, vecs[i].dec, vecs[i].tick, vecs[i].busy}));
        end
        upd_strobe = 1'b0;

        // Frame period
        t_first = -1; t_second = -1;
        for (int i = 0; i < 60; i++) begin
            step();
            if (frame_tick === 1'b1) begin
                if (t_first < 0) t_first = cyc;
                else if (t_second < 0) t_second = cyc;
            end
        end
        check("frame_period", 32'(t_second - t_first), 32'(FRAME));

        // Mid-frame update stays pending until the boundary
        wait_sel(4'b1101, "t3_d1");
        upd_strobe = 1'b1; upd_codes = '0;
        step();
        upd_strobe = 1'b0; upd_codes = codes_c;
        check("t3_busy_set", 32'(upd_busy), 32'd1);
        wait_tick("t3_tick");
        check("t3_busy_at_tick", 32'(upd_busy), 32'd1);
        wait_sel(4'b1110, "t3_d0");
        check("t3_busy_clear", 32'(upd_busy), 32'd0);
        check("t3_dec_zero", 32'({dec_a, dec_b, dec_c}), 32'd0);

        // Strobe in the boundary cycle applies immediately
        wait_tick("t4_tick");
        upd_strobe = 1'b1; upd_codes = codes_d;
        step();
        upd_strobe = 1'b0; upd_codes = '0;
        busy_seen = (upd_busy === 1'b1) ? 1 : 0;
        for (int i = 0; i < 100 && digit_sel !== 4'b1110; i++) begin
            step();
            if (upd_busy === 1'b1) busy_seen++;
        end
        check("t4_busy_never", 32'(busy_seen), 32'd0);
        check("t4_dec_new", 32'({dec_a, dec_b, dec_c}), 32'd3);

        // Masked digit stays dark, then enable drop finishes the slot
        digit_mask = 4'b1011;
        lit2 = 0;
        for (int i = 0; i < int'(FRAME); i++) begin
            step();
            if (digit_sel[2] === 1'b0) lit2++;
        end
        check("t5_mask_dark", 32'(lit2), 32'd0);
        wait_sel(4'b1101, "t5_d1");
        en = 1'b0;
        for (int i = 0; i < 10; i++) step();
        check("t5_idle_off", 32'(digit_sel), 32'hF);
        digit_mask = 4'b1111;

        // Reset mid-slot blanks immediately and restarts with zero codes
        en = 1'b1;
        wait_sel(4'b1011, "t6_d2");
        rst_n = 1'b0;
        step();
        check("t6_rst_sel", 32'(digit_sel), 32'hF);
        rst_n = 1'b1;
        wait_sel(4'b1110, "t6_d0");
        check("t6_dec_zero", 32'({dec_a, dec_b, dec_c}), 32'd0);

        // Randomized traffic against the model
        for (int i = 0; i < 3000; i++) begin
            rst_n      = ($urandom_range(0, 199) != 0);
            en         = ($urandom_range(0, 9) != 0);
            upd_strobe = ($urandom_range(0, 7) == 0);
            upd_codes  = 12'($urandom);
            if ($urandom_range(0, 19) == 0) digit_mask = 4'($urandom);
            step();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
